// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, LSB first, one bit per clock
// Start/done handshake; diff, borrow_out and overflow hold until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             serial_subtractor_clk,
  input  logic             serial_subtractor_rst,
  input  logic             serial_subtractor_start,
  input  logic [WIDTH-1:0] serial_subtractor_a,
  input  logic [WIDTH-1:0] serial_subtractor_b,
  input  logic             serial_subtractor_borrow_in,
  output logic             serial_subtractor_busy,
  output logic             serial_subtractor_done,
  output logic [WIDTH-1:0] serial_subtractor_diff,
  output logic             serial_subtractor_borrow_out,
  output logic             serial_subtractor_overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [CW-1:0]    cnt;
  logic             borrow, borrow_next, res_bit;
  logic             a_msb, b_msb;
  logic             accept, last_bit;

  assign accept   = serial_subtractor_start && (state == IDLE || state == DONE);
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  // Registered full-subtractor cell: borrow feeds back through a flop.
  assign res_bit     = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign res_next    = {res_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge serial_subtractor_clk or posedge serial_subtractor_rst) begin
    if (serial_subtractor_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (serial_subtractor_start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = serial_subtractor_start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge serial_subtractor_clk or posedge serial_subtractor_rst) begin
    if (serial_subtractor_rst) begin
      a_sr                         <= '0;
      b_sr                         <= '0;
      res_sr                       <= '0;
      cnt                          <= '0;
      borrow                       <= 1'b0;
      a_msb                        <= 1'b0;
      b_msb                        <= 1'b0;
      serial_subtractor_diff       <= '0;
      serial_subtractor_borrow_out <= 1'b0;
      serial_subtractor_overflow   <= 1'b0;
    end else if (accept) begin
      a_sr   <= serial_subtractor_a;
      b_sr   <= serial_subtractor_b;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= serial_subtractor_borrow_in;
      a_msb  <= serial_subtractor_a[WIDTH-1];
      b_msb  <= serial_subtractor_b[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_next;
      borrow <= borrow_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        serial_subtractor_diff       <= res_next;
        serial_subtractor_borrow_out <= borrow_next;
        // Signed overflow: operand signs differ and result sign departs from the minuend.
        serial_subtractor_overflow   <= (a_msb != b_msb) && (res_bit != a_msb);
      end
    end
  end

  assign serial_subtractor_busy = (state == SHIFT);
  assign serial_subtractor_done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
// Stimulus pushes expected results; a negedge monitor pops them on done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           t;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .serial_subtractor_clk       (clk),
    .serial_subtractor_rst       (rst),
    .serial_subtractor_start     (start),
    .serial_subtractor_a         (a),
    .serial_subtractor_b         (b),
    .serial_subtractor_borrow_in (bin),
    .serial_subtractor_busy      (busy),
    .serial_subtractor_done      (done),
    .serial_subtractor_diff      (diff),
    .serial_subtractor_borrow_out(bout),
    .serial_subtractor_overflow  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on every done, guard invariants every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) chk("busy_done_exclusive", 1, 0);
      if (busy) chk("diff_hold_in_shift", int'(diff), int'(last_diff));
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diff", int'(diff), int'(e.d));
          chk("borrow_out", int'(bout), int'(e.bo));
          chk("overflow", int'(ovf), int'(e.ov));
          chk("done_cycle", cyc, e.t);
          last_diff = e.d;
        end
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] d, input logic bo, input logic ov, input int t);
    exp_t e;
    e.d = d; e.bo = bo; e.ov = ov; e.t = t;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic ebo, input logic eov);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(ed, ebo, eov, cyc + W);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_diff"}, int'(diff), 0);
    chk({tag, "_borrow_out"}, int'(bout), 0);
    chk({tag, "_overflow"}, int'(ovf), 0);
  endtask

  initial begin
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    drain();
    issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    drain();
    issue(8'h03, 8'h05, 1'b1, 8'hFD, 1'b1, 1'b0);
    drain();
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    drain();
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    drain();

    // start pulsed in SHIFT cycle 3 must be ignored
    issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (W + 4) @(posedge clk);

    // back-to-back: start held through DONE
    begin
      int k;
      @(negedge clk);
      a = 8'h20; b = 8'h05; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      push_exp(8'h1B, 1'b0, 1'b0, k + W);
      a = 8'h40; b = 8'h50;
      repeat (W + 1) @(posedge clk);
      #1;
      start = 1'b0;
      push_exp(8'hF0, 1'b1, 1'b0, k + 2 * W + 1);
      drain();
    end

    // reset in SHIFT cycle 4 aborts with no done
    issue(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    sb.delete();
    last_diff = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(posedge clk);
    issue(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
